// File: rtl/mux4_demux_buf.sv
// One-to-three demultiplexer feeding independent one-entry output buffers.
// Words addressed to code 00 are dropped and tallied in a saturating counter.
module mux4_demux_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic             out_valid1,
   output logic             out_valid2,
   output logic             out_valid3,
   input  logic             out_ready1,
   input  logic             out_ready2,
   input  logic             out_ready3,
   output logic [7:0]       drop_count
);

   logic [2:0]       out_ready_v;
   logic [2:0]       out_valid_v;
   logic [WIDTH-1:0] out_data_a [3];
   logic             in_fire;
   logic [7:0]       drop_count_q;
   logic [7:0]       drop_count_d;

   assign out_ready_v = {out_ready3, out_ready2, out_ready1};

   // Readiness looks only at the addressed channel, so a stalled channel never blocks the others.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (in_sel)
            2'b00:   in_ready = 1'b1;
            2'b01:   in_ready = !out_valid_v[0] || out_ready_v[0];
            2'b10:   in_ready = !out_valid_v[1] || out_ready_v[1];
            default: in_ready = !out_valid_v[2] || out_ready_v[2];
         endcase
      end
   end

   assign in_fire = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_ch
         logic [WIDTH-1:0] data_q;
         logic [WIDTH-1:0] data_d;
         logic             valid_q;
         logic             valid_d;
         logic             load;

         // A load on the same edge as a pop keeps the buffer full with the new word.
         always_comb begin
            load    = in_fire && (in_sel == 2'(gi + 1));
            valid_d = valid_q && !out_ready_v[gi];
            data_d  = data_q;
            if (load) begin
               valid_d = 1'b1;
               data_d  = in_data;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
            end
         end

         assign out_valid_v[gi] = valid_q;
         assign out_data_a[gi]  = data_q;
      end
   endgenerate

   always_comb begin
      drop_count_d = drop_count_q;
      if (in_fire && (in_sel == 2'b00) && (drop_count_q != 8'hFF))
         drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_count_q <= 8'd0;
      else       drop_count_q <= drop_count_d;
   end

   assign out_valid1 = out_valid_v[0];
   assign out_valid2 = out_valid_v[1];
   assign out_valid3 = out_valid_v[2];
   assign out_data1  = out_data_a[0];
   assign out_data2  = out_data_a[1];
   assign out_data3  = out_data_a[2];
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mux4_demux_buf.sv
// Self-checking bench for mux4_demux_buf: directed scenarios plus a randomized
// run against a queue-style model of the three buffers and the drop tally.
module tb_mux4_demux_buf;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data1, out_data2, out_data3;
   logic       out_valid1, out_valid2, out_valid3;
   logic [2:0] ord;
   logic [7:0] drop_count;

   logic [2:0] ov;
   logic [7:0] od [3];

   int n_cmp = 0;
   int n_err = 0;

   // Model: per channel a held word (0 or 1 entry) and the last word written.
   logic [7:0] m_data [3];
   logic       m_full [3];
   int         m_drops;

   always #5 clk = ~clk;

   mux4_demux_buf #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_data3  (out_data3),
      .out_valid1 (out_valid1),
      .out_valid2 (out_valid2),
      .out_valid3 (out_valid3),
      .out_ready1 (ord[0]),
      .out_ready2 (ord[1]),
      .out_ready3 (ord[2]),
      .drop_count (drop_count)
   );

   assign ov    = {out_valid3, out_valid2, out_valid1};
   assign od[0] = out_data1;
   assign od[1] = out_data2;
   assign od[2] = out_data3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      ord      = 3'b000;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic model_clear();
      for (int c = 0; c < 3; c++) begin
         m_data[c] = 8'h00;
         m_full[c] = 1'b0;
      end
      m_drops = 0;
   endtask

   // Applies the rules of one clock edge to the model using the current inputs.
   task automatic model_edge(output logic acc);
      int k;
      k   = int'(in_sel);
      acc = in_valid && ((k == 0) || !m_full[k-1] || ord[k-1]);
      for (int c = 0; c < 3; c++)
         if (m_full[c] && ord[c]) m_full[c] = 1'b0;
      if (acc) begin
         if (k == 0) begin
            if (m_drops < 255) m_drops++;
         end else begin
            m_full[k-1] = 1'b1;
            m_data[k-1] = in_data;
         end
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_sel   = 2'b00;
      in_data  = 8'hEE;
      ord      = 3'b000;
      #2;
      n_cmp++; if (ov !== 3'b000)      begin n_err++; $display("FAIL reset_valid got=%b exp=000", ov); end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop got=%0h exp=0", drop_count); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_rdy got=%b exp=0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (od[c] !== 8'h00) begin n_err++; $display("FAIL reset_data%0d got=%0h exp=00", c + 1, od[c]); end
      end
      // Offer a word to channel 3 while reset is still high; it must land on the first edge after release.
      in_sel  = 2'b11;
      in_data = 8'h77;
      @(negedge clk);
      reset = 1'b0;
      tick();
      n_cmp++; if (ov[2] !== 1'b1 || od[2] !== 8'h77) begin n_err++; $display("FAIL first_xfer got=%b/%0h exp=1/77", ov[2], od[2]); end
      in_sel  = 2'b10;
      in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (ov[1] !== 1'b1 || od[1] !== 8'h5A) begin n_err++; $display("FAIL load5a got=%b/%0h exp=1/5a", ov[1], od[1]); end
      #3;
      in_sel   = 2'b00;
      in_valid = 1'b1;
      reset    = 1'b1;
      #1;
      n_cmp++; if (ov !== 3'b000)       begin n_err++; $display("FAIL async_valid got=%b exp=000", ov); end
      n_cmp++; if (od[1] !== 8'h00)     begin n_err++; $display("FAIL async_data2 got=%0h exp=00", od[1]); end
      n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL async_drop got=%0h exp=0", drop_count); end
      n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL async_rdy got=%b exp=0", in_ready); end
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_fill_stall();
      do_reset();
      in_valid = 1'b1; in_sel = 2'b01; in_data = 8'hA3; ord = 3'b000;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_rdy_empty got=%b exp=1", in_ready); end
      tick();
      n_cmp++; if (ov[0] !== 1'b1 || od[0] !== 8'hA3) begin n_err++; $display("FAIL fill_a3 got=%b/%0h exp=1/a3", ov[0], od[0]); end
      in_data = 8'hB4;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_rdy_full got=%b exp=0", in_ready); end
      tick();
      n_cmp++; if (od[0] !== 8'hA3) begin n_err++; $display("FAIL fill_stable got=%0h exp=a3", od[0]); end
      ord = 3'b001;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_rdy_pop got=%b exp=1", in_ready); end
      tick();
      n_cmp++; if (ov[0] !== 1'b1 || od[0] !== 8'hB4) begin n_err++; $display("FAIL fill_b4 got=%b/%0h exp=1/b4", ov[0], od[0]); end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (ov[0] !== 1'b0 || od[0] !== 8'hB4) begin n_err++; $display("FAIL fill_drain got=%b/%0h exp=0/b4", ov[0], od[0]); end
      ord = 3'b000;
      $display("test_fill_stall done");
   endtask

   task automatic test_independent();
      do_reset();
      in_valid = 1'b1; in_sel = 2'b11; in_data = 8'h11; ord = 3'b000;
      tick();
      in_sel = 2'b10; in_data = 8'h22;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL indep_rdy22 got=%b exp=1", in_ready); end
      tick();
      in_sel = 2'b01; in_data = 8'h33;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL indep_rdy33 got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (ov !== 3'b111) begin n_err++; $display("FAIL indep_valid got=%b exp=111", ov); end
      n_cmp++; if (od[2] !== 8'h11 || od[1] !== 8'h22 || od[0] !== 8'h33)
         begin n_err++; $display("FAIL indep_data got=%0h/%0h/%0h exp=11/22/33", od[2], od[1], od[0]); end
      ord = 3'b111;
      tick();
      n_cmp++; if (ov !== 3'b000) begin n_err++; $display("FAIL indep_drain got=%b exp=000", ov); end
      ord = 3'b000;
      $display("test_independent done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_word;
      do_reset();
      in_valid = 1'b1; in_sel = 2'b10; in_data = 8'hFF; ord = 3'b000;
      tick();
      ord = 3'b010;
      for (int i = 1; i <= 16; i++) begin
         in_data  = 8'(i);
         exp_word = (i == 1) ? 8'hFF : 8'(i - 1);
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy%0d got=%b exp=1", i, in_ready); end
         n_cmp++; if (ov[1] !== 1'b1 || od[1] !== exp_word)
            begin n_err++; $display("FAIL b2b_word%0d got=%b/%0h exp=1/%0h", i, ov[1], od[1], exp_word); end
         $display("b2b consumer takes %0h", od[1]);
         tick();
      end
      in_valid = 1'b0;
      n_cmp++; if (ov[1] !== 1'b1 || od[1] !== 8'h10) begin n_err++; $display("FAIL b2b_last got=%b/%0h exp=1/10", ov[1], od[1]); end
      tick();
      n_cmp++; if (ov[1] !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", ov[1]); end
      ord = 3'b000;
      $display("test_back_to_back done");
   endtask

   task automatic test_drop_sat();
      int exp_cnt;
      do_reset();
      in_valid = 1'b1; in_sel = 2'b00; ord = 3'b000;
      for (int i = 0; i < 260; i++) begin
         in_data = 8'($urandom);
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_rdy%0d got=%b exp=1", i, in_ready); end
         tick();
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         n_cmp++; if (drop_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL drop_cnt%0d got=%0d exp=%0d", i, drop_count, exp_cnt); end
      end
      in_valid = 1'b0;
      n_cmp++; if (ov !== 3'b000) begin n_err++; $display("FAIL drop_valid got=%b exp=000", ov); end
      $display("test_drop_sat done count=%0d", drop_count);
   endtask

   task automatic test_idle();
      do_reset();
      in_valid = 1'b0; ord = 3'b100;
      for (int i = 0; i < 8; i++) begin
         in_sel  = (i % 2 == 0) ? 2'b11 : 2'(i % 3);
         in_data = 8'($urandom);
         #1;
         if (in_sel == 2'b11) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_rdy%0d got=%b exp=1", i, in_ready); end
         end
         tick();
         n_cmp++; if (ov !== 3'b000 || drop_count !== 8'd0)
            begin n_err++; $display("FAIL idle_state%0d got=%b/%0d exp=000/0", i, ov, drop_count); end
      end
      ord = 3'b000;
      $display("test_idle done");
   endtask

   task automatic test_random();
      logic acc;
      logic exp_rdy;
      int   k;
      do_reset();
      model_clear();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_sel   = 2'($urandom);
         in_data  = 8'($urandom);
         ord      = 3'($urandom);
         #1;
         k       = int'(in_sel);
         exp_rdy = (k == 0) || !m_full[k-1] || ord[k-1];
         n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_rdy%0d got=%b exp=%b", i, in_ready, exp_rdy); end
         model_edge(acc);
         if (acc) $display("rnd %0d accept sel=%0d data=%0h", i, in_sel, in_data);
         tick();
         for (int c = 0; c < 3; c++) begin
            n_cmp++; if (ov[c] !== m_full[c] || od[c] !== m_data[c])
               begin n_err++; $display("FAIL rnd_ch%0d_%0d got=%b/%0h exp=%b/%0h", c + 1, i, ov[c], od[c], m_full[c], m_data[c]); end
         end
         n_cmp++; if (drop_count !== 8'(m_drops)) begin n_err++; $display("FAIL rnd_drop%0d got=%0d exp=%0d", i, drop_count, m_drops); end
      end
      in_valid = 1'b0;
      ord      = 3'b000;
      $display("test_random done");
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sel   = 2'b00;
      in_data  = 8'h00;
      ord      = 3'b000;
      test_reset();
      test_fill_stall();
      test_independent();
      test_back_to_back();
      test_drop_sat();
      test_idle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux4_demux_buf.md
MUX4_DEMUX_BUF -- requirements
Module: mux4_demux_buf

Interface
REQ-001: Parameter WIDTH, default 8, data width of the input channel and of each output channel.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: in_data  input  WIDTH  data word offered by the producer.
REQ-005: in_sel  input  2  destination code: 01 = channel 1, 10 = channel 2, 11 = channel 3, 00 = discard.
REQ-006: in_valid  input  1  producer holds in_data/in_sel valid.
REQ-007: in_ready  output  1  block accepts the offered word this cycle.
REQ-008: out_data1, out_data2, out_data3  output  WIDTH each  held word of channel k.
REQ-009: out_valid1, out_valid2, out_valid3  output  1 each  channel k holds an undelivered word.
REQ-010: out_ready1, out_ready2, out_ready3  input  1 each  consumer k takes the word this cycle.
REQ-011: drop_count  output  8  saturating count of words accepted with in_sel = 00.

Function
REQ-012: Input transfer SHALL occur on a rising edge where in_valid = 1 and in_ready = 1; no other input state changes anything.
REQ-013: Each channel k SHALL have a one-entry holding register (data plus valid flag).
REQ-014: in_ready SHALL be combinational: 1 when in_sel = 00; else 1 when channel k selected by in_sel has out_valid_k = 0, or out_valid_k = 1 and out_ready_k = 1 in the same cycle; else 0.
REQ-015: in_ready SHALL NOT depend on the state or ready of non-selected channels.
REQ-016: On transfer with in_sel selecting channel k, out_data_k SHALL take in_data and out_valid_k SHALL be 1 from the next cycle (latency 1 cycle).
REQ-017: Output transfer on channel k SHALL occur on a rising edge where out_valid_k = 1 and out_ready_k = 1.
REQ-018: Output transfer with no simultaneous load into channel k SHALL clear out_valid_k; out_data_k keeps its last value.
REQ-019: Simultaneous output transfer and load on channel k SHALL leave out_valid_k = 1 with the new word (full throughput, one word per cycle per channel).
REQ-020: While out_valid_k = 1 and out_ready_k = 0, out_data_k SHALL remain stable.
REQ-021: Channels SHALL operate independently; a stalled channel SHALL NOT block words to other channels.
REQ-022: Transfer with in_sel = 00 SHALL discard in_data and increment drop_count by 1, saturating at 255 (no wrap).
REQ-023: Per channel, words SHALL be delivered in acceptance order; none duplicated or lost except by reset.
REQ-024: out_ready_k while out_valid_k = 0 SHALL have no effect.

Reset
REQ-025: While reset = 1, all state SHALL clear asynchronously: out_valid1..3 = 0, out_data1..3 = 0, drop_count = 0.
REQ-026: While reset = 1, in_ready SHALL be 0.
REQ-027: Reset mid-operation SHALL discard all held words; no partial transfer occurs on the edge reset deasserts.
REQ-028: First transfer possible on the first rising edge after reset deasserts.

Verification
REQ-029: Reset asserted mid-cycle with out_valid2 = 1 (data 8'h5A) -> out_valid2 = 0, out_data2 = 8'h00, drop_count = 0, in_ready = 0 immediately, no clock edge needed.
REQ-030: in_sel = 01, in_data = 8'hA3, in_valid = 1, out_ready1 = 0 -> next cycle out_valid1 = 1, out_data1 = 8'hA3; second word 8'hB4 to sel 01 sees in_ready = 0 until out_ready1 = 1, then out_data1 = 8'hB4 one cycle later.
REQ-031: Channel 3 stalled with word 8'h11, then words 8'h22 (sel 10) and 8'h33 (sel 01) -> both accepted back-to-back, in_ready = 1 each cycle, out_data3 stays 8'h11.
REQ-032: Channel 2 full, out_ready2 = 1 held, stream 8'h01..8'h10 to sel 10 on consecutive cycles -> in_ready = 1 throughout, out_valid2 = 1 throughout, consumer receives 16 words in order.
REQ-033: 260 consecutive transfers with in_sel = 00 -> drop_count reaches 255 and holds 255; all out_valid_k remain 0.
REQ-034: in_valid = 0 with in_sel = 11 toggling and out_ready3 = 1 -> no state change, out_valid3 stays 0.
